// File: rtl/regfile_wr_arbiter_pkg.sv
// rtl/regfile_wr_arbiter_pkg.sv - shared sizes and FSM encoding for the regfile port arbiter
package regfile_wr_arbiter_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// rtl/regfile_wr_arbiter_if.sv - debug/host req/ack access channel into the regfile arbiter
interface regfile_wr_arbiter_if #(
    parameter int AW = regfile_wr_arbiter_pkg::RF_AW,
    parameter int DW = regfile_wr_arbiter_pkg::RF_DW
);

    logic          dbg_req;
    logic          dbg_wr;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;

    modport master (
        output dbg_req, dbg_wr, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata
    );

    modport slave (
        input  dbg_req, dbg_wr, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata
    );

endinterface

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - zero-sweeps regfile_dp after reset, then shares its ports between core and debug
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int AW           = RF_AW,
    parameter int DW           = RF_DW,
    parameter int STARVE_LIMIT = 15,
    parameter int PROTECT_X0   = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clr_req,
    output logic                 init_busy,
    output logic                 cpu_stall,
    input  logic                 cpu_we,
    input  logic [AW-1:0]        cpu_waddr,
    input  logic [DW-1:0]        cpu_wdata,
    input  logic                 cpu_re,
    input  logic [AW-1:0]        cpu_raddr,
    regfile_wr_arbiter_if.slave  dbg,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [DW-1:0]        rf_di,
    output logic [AW-1:0]        rf_raddr,
    input  logic [DW-1:0]        rf_do
);

    localparam logic [AW:0] SWEEP_LAST = (AW+1)'((1 << AW) - 1);
    localparam logic [7:0]  STARVE_MAX = 8'(STARVE_LIMIT);
    localparam bit          PROT       = (PROTECT_X0 != 0);

    arb_state_e   state;
    logic [AW:0]  sweep_cnt;
    logic [7:0]   starve_cnt;

    logic cpu_wr_ok;
    logic dbg_pend;
    logic dbg_wr_drop;
    logic dbg_grant;

    // A pending request is one not already being acked, so each req yields one transaction.
    always_comb begin
        cpu_wr_ok   = cpu_we && !(PROT && cpu_waddr == '0);
        dbg_pend    = dbg.dbg_req && !dbg.dbg_ack;
        dbg_wr_drop = PROT && dbg.dbg_addr == '0;
        dbg_grant   = 1'b0;
        case (state)
            ST_RUN:   dbg_grant = dbg_pend && (dbg.dbg_wr ? !cpu_wr_ok : !cpu_re);
            ST_FORCE: dbg_grant = dbg_pend;
            default:  dbg_grant = 1'b0;
        endcase
    end

    assign cpu_stall = (state != ST_RUN);

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = cpu_waddr;
        rf_di    = cpu_wdata;
        rf_raddr = cpu_raddr;
        case (state)
            ST_INIT: begin
                rf_we    = 1'b1;
                rf_waddr = sweep_cnt[AW-1:0];
                rf_di    = '0;
            end
            default: begin
                // In FORCE the core's enables are ignored; the grant already excludes a live core access in RUN.
                rf_we = (state == ST_RUN) && cpu_wr_ok;
                if (dbg_grant) begin
                    if (dbg.dbg_wr) begin
                        rf_we    = !dbg_wr_drop;
                        rf_waddr = dbg.dbg_addr;
                        rf_di    = dbg.dbg_wdata;
                    end else begin
                        rf_raddr = dbg.dbg_addr;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_INIT;
            sweep_cnt     <= '0;
            init_busy     <= 1'b1;
            starve_cnt    <= '0;
            dbg.dbg_ack   <= 1'b0;
            dbg.dbg_rdata <= '0;
        end else begin
            dbg.dbg_ack <= dbg_grant;
            if (dbg_grant && !dbg.dbg_wr) begin
                dbg.dbg_rdata <= rf_do;
            end
            case (state)
                ST_INIT: begin
                    sweep_cnt  <= sweep_cnt + 1'b1;
                    starve_cnt <= '0;
                    if (sweep_cnt == SWEEP_LAST) begin
                        state     <= ST_RUN;
                        init_busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (dbg_grant || !dbg_pend) begin
                        starve_cnt <= '0;
                    end else begin
                        starve_cnt <= starve_cnt + 8'd1;
                        if (starve_cnt + 8'd1 == STARVE_MAX) begin
                            state <= ST_FORCE;
                        end
                    end
                    if (clr_req) begin
                        state      <= ST_INIT;
                        sweep_cnt  <= '0;
                        init_busy  <= 1'b1;
                        starve_cnt <= '0;
                    end
                end
                ST_FORCE: begin
                    state      <= ST_RUN;
                    starve_cnt <= '0;
                end
                default: begin
                    state     <= ST_INIT;
                    sweep_cnt <= '0;
                    init_busy <= 1'b1;
                end
            endcase
        end
    end

endmodule
